// File: rtl/conv3x3_rgb888.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : conv3x3_rgb888                                             |
// | Description : Per-channel 3x3 convolution on RGB888 windows (bypass,     |
// |               gaussian, sharpen, laplacian edge). Writes one filtered    |
// |               pixel per accepted window to the output frame BRAM.        |
// |               Window accepted at edge N appears on oWe/oPixel after      |
// |               edge N+3. A small FSM tracks frame completion.             |
// | Option      : CONV_GRAY_OUT_EN - output luma {Y,Y,Y} instead of RGB,     |
// |               Y = (77R + 150G + 29B) >> 8, same latency.                 |
// | Ports       : iClk, iRst (sync, active-low), iStart, iMode[1:0],         |
// |               iWin0..iWin8 (row-major, 4 = centre), iValid,              |
// |               oWe, oAddr, oPixel (BRAM write side), oBusy, oDone.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module conv3x3_rgb888 #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 17,
  parameter int WIDTH  = 480,
  parameter int HEIGHT = 272,
  parameter int DEPTH  = WIDTH * HEIGHT
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic [1:0]        iMode,
  input  logic [DATA_W-1:0] iWin0,
  input  logic [DATA_W-1:0] iWin1,
  input  logic [DATA_W-1:0] iWin2,
  input  logic [DATA_W-1:0] iWin3,
  input  logic [DATA_W-1:0] iWin4,
  input  logic [DATA_W-1:0] iWin5,
  input  logic [DATA_W-1:0] iWin6,
  input  logic [DATA_W-1:0] iWin7,
  input  logic [DATA_W-1:0] iWin8,
  input  logic              iValid,
  output logic              oWe,
  output logic [ADDR_W-1:0] oAddr,
  output logic [DATA_W-1:0] oPixel,
  output logic              oBusy,
  output logic              oDone
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_mode;
  logic [ADDR_W-1:0] r_in_cnt;
  logic              r_acc_vld;
  logic              r_s1_vld;
  logic              r_s2_vld;
  logic [DATA_W-1:0] w_s2_pix;
  logic [DATA_W-1:0] w_out;
  logic              w_accept;
  logic              w_last_in;
  logic              w_last_wr;

  // Windows are only taken while running; a start cycle is never a data cycle.
  assign w_accept  = (r_state == S_RUN) && iValid;
  assign w_last_in = w_accept && (r_in_cnt == LAST_IDX);
  assign w_last_wr = oWe && (oAddr == LAST_IDX);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    oBusy  = 1'b0;
    oDone  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (iStart) w_next = S_RUN;
      end
      S_RUN: begin
        oBusy = 1'b1;
        if (w_last_in) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        oBusy = 1'b1;
        if (w_last_wr) w_next = S_DONE;
      end
      S_DONE: begin
        oDone  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Mode is frozen for the whole frame; input window counter.
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      r_mode   <= 2'd0;
      r_in_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && iStart) begin
        r_mode   <= iMode;
        r_in_cnt <= '0;
      end else if (w_accept) begin
        r_in_cnt <= w_last_in ? '0 : r_in_cnt + 1'b1;
      end
    end
  end

  // Valid shift chain: accept -> S1 -> S2 -> S3 (oWe).
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      r_acc_vld <= 1'b0;
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
    end else begin
      r_acc_vld <= w_accept;
      r_s1_vld  <= r_acc_vld;
      r_s2_vld  <= r_s1_vld;
    end
  end

  // ---------------------------------------------------------------- channels
  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    logic [7:0]         r_c;
    logic [9:0]         r_e;
    logic [9:0]         r_k;
    logic [9:0]         w_e;
    logic [9:0]         w_k;
    logic signed [12:0] w_c13;
    logic signed [12:0] w_e13;
    logic signed [12:0] w_k13;
    logic signed [12:0] w_sum;
    logic signed [12:0] r_s1_sum;
    logic signed [12:0] w_abs;
    logic [7:0]         w_norm;
    logic [7:0]         r_s2_ch;

    // Kernels only ever weight the edge group and the corner group as a
    // whole, so the accept stage folds the nine taps into three values.
    assign w_e = {2'b00, iWin1[8*ch +: 8]} + {2'b00, iWin3[8*ch +: 8]}
               + {2'b00, iWin5[8*ch +: 8]} + {2'b00, iWin7[8*ch +: 8]};
    assign w_k = {2'b00, iWin0[8*ch +: 8]} + {2'b00, iWin2[8*ch +: 8]}
               + {2'b00, iWin6[8*ch +: 8]} + {2'b00, iWin8[8*ch +: 8]};

    always_ff @(posedge iClk) begin
      if (!iRst) begin
        r_c <= '0;
        r_e <= '0;
        r_k <= '0;
      end else if (w_accept) begin
        r_c <= iWin4[8*ch +: 8];
        r_e <= w_e;
        r_k <= w_k;
      end
    end

    assign w_c13 = $signed({5'b0_0000, r_c});
    assign w_e13 = $signed({3'b000, r_e});
    assign w_k13 = $signed({3'b000, r_k});

    // S1: signed kernel sum, worst case -2040..4080 fits 13 bits.
    always_comb begin
      w_sum = w_c13;
      case (r_mode)
        2'd1:    w_sum = (w_c13 <<< 2) + (w_e13 <<< 1) + w_k13;
        2'd2:    w_sum = (w_c13 <<< 2) + w_c13 - w_e13;
        2'd3:    w_sum = (w_c13 <<< 3) - w_e13 - w_k13;
        default: w_sum = w_c13;
      endcase
    end

    always_ff @(posedge iClk) begin
      if (!iRst) begin
        r_s1_sum <= '0;
      end else if (r_acc_vld) begin
        r_s1_sum <= w_sum;
      end
    end

    // S2: normalise to 8 bits.
    always_comb begin
      w_norm = r_s1_sum[7:0];
      w_abs  = r_s1_sum;
      case (r_mode)
        2'd1: w_norm = r_s1_sum[11:4];
        2'd2: begin
          if (r_s1_sum < 13'sd0)        w_norm = 8'h00;
          else if (r_s1_sum > 13'sd255) w_norm = 8'hFF;
          else                          w_norm = r_s1_sum[7:0];
        end
        2'd3: begin
          if (r_s1_sum < 13'sd0) w_abs = -r_s1_sum;
          if (w_abs > 13'sd255)  w_norm = 8'hFF;
          else                   w_norm = w_abs[7:0];
        end
        default: w_norm = r_s1_sum[7:0];
      endcase
    end

    always_ff @(posedge iClk) begin
      if (!iRst) begin
        r_s2_ch <= '0;
      end else if (r_s1_vld) begin
        r_s2_ch <= w_norm;
      end
    end

    assign w_s2_pix[8*ch +: 8] = r_s2_ch;
  end

  // ---------------------------------------------------------------- S3
`ifdef CONV_GRAY_OUT_EN
  logic [15:0] w_y_sum;
  logic [7:0]  w_y;
  assign w_y_sum = 16'd77  * {8'd0, w_s2_pix[23:16]}
                 + 16'd150 * {8'd0, w_s2_pix[15:8]}
                 + 16'd29  * {8'd0, w_s2_pix[7:0]};
  assign w_y     = 8'(w_y_sum >> 8);
  assign w_out   = {w_y, w_y, w_y};
`else
  assign w_out = w_s2_pix;
`endif

  // oAddr holds the address of the write currently presented and advances
  // on the edge that retires that write, wrapping after the last pixel.
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      oWe    <= 1'b0;
      oAddr  <= '0;
      oPixel <= '0;
    end else begin
      oWe <= r_s2_vld;
      if (r_s2_vld) oPixel <= w_out;
      if (oWe)      oAddr  <= w_last_wr ? '0 : oAddr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_rgb888.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_conv3x3_rgb888                                          |
// | Description : Self-checking bench for conv3x3_rgb888 on a reduced        |
// |               16x8 frame. Expected pixels go into a queue as windows are |
// |               driven and are compared when the DUT writes.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_conv3x3_rgb888;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int D  = W * H;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          valid = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [23:0]   win [9];
  logic          we;
  logic [AW-1:0] addr;
  logic [23:0]   pixel;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_addr = 0;
  int wr_cnt = 0;
  int last_wr_cyc = -10;
  int cur_mode = 0;
  int sent = 0;
  bit in_run = 1'b0;
  logic [23:0] exp_q [$];
  logic [23:0] mon_exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  conv3x3_rgb888 #(
    .DATA_W(24), .ADDR_W(AW), .WIDTH(W), .HEIGHT(H), .DEPTH(D)
  ) dut (
    .iClk(clk), .iRst(rst_n), .iStart(start), .iMode(mode),
    .iWin0(win[0]), .iWin1(win[1]), .iWin2(win[2]),
    .iWin3(win[3]), .iWin4(win[4]), .iWin5(win[5]),
    .iWin6(win[6]), .iWin7(win[7]), .iWin8(win[8]),
    .iValid(valid),
    .oWe(we), .oAddr(addr), .oPixel(pixel), .oBusy(busy), .oDone(done)
  );

  // Reference model, one channel.
  function automatic int ch_model(input int m, input int c, input int e, input int k);
    int v;
    case (m)
      0: v = c;
      1: v = (4 * c + 2 * e + k) / 16;
      2: begin
        v = 5 * c - e;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
      end
      3: begin
        v = 8 * c - e - k;
        if (v < 0) v = -v;
        if (v > 255) v = 255;
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic [23:0] px_model(input int m);
    logic [23:0] r;
    r = '0;
    for (int ch = 0; ch < 3; ch++) begin
      int c, e, k;
      c = int'(win[4][8*ch +: 8]);
      e = int'(win[1][8*ch +: 8]) + int'(win[3][8*ch +: 8])
        + int'(win[5][8*ch +: 8]) + int'(win[7][8*ch +: 8]);
      k = int'(win[0][8*ch +: 8]) + int'(win[2][8*ch +: 8])
        + int'(win[6][8*ch +: 8]) + int'(win[8][8*ch +: 8]);
      r[8*ch +: 8] = 8'(ch_model(m, c, e, k));
    end
    return r;
  endfunction

  // Write monitor: every DUT write pops one expectation.
  always @(negedge clk) begin
    if (rst_n && we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d pixel=%h, required no write", addr, pixel);
      end else begin
        mon_exp = exp_q.pop_front();
        if (pixel !== mon_exp) begin
          errors++;
          $display("FAIL pixel@%0d: got %h, expected %h (mode %0d)", exp_addr, pixel, mon_exp, cur_mode);
        end
      end
      checks++;
      if (addr !== AW'(exp_addr)) begin
        errors++;
        $display("FAIL write_addr: got %0d, expected %0d", addr, exp_addr);
      end
      exp_addr    = (exp_addr == D - 1) ? 0 : exp_addr + 1;
      wr_cnt      = wr_cnt + 1;
      last_wr_cyc = cyc;
    end
  end

  task automatic rand_win();
    for (int i = 0; i < 9; i++) win[i] = 24'($urandom);
  endtask

  task automatic set_win(input logic [23:0] c, input logic [23:0] e, input logic [23:0] k);
    win[4] = c;
    win[1] = e; win[3] = e; win[5] = e; win[7] = e;
    win[0] = k; win[2] = k; win[6] = k; win[8] = k;
  endtask

  // Drives one cycle; call 1 time unit after a rising edge.
  task automatic send_window(input logic vld, input logic [23:0] exp, input bit use_exp);
    valid = vld;
    if (vld && in_run && sent < D) begin
      exp_q.push_back(use_exp ? exp : px_model(cur_mode));
      sent++;
    end
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  // Start pulse; with_window also raises iValid, which must be dropped.
  task automatic start_frame(input int m, input bit with_window);
    rand_win();
    start = 1'b1;
    mode  = 2'(m);
    valid = with_window;
    @(posedge clk); #1;
    start    = 1'b0;
    valid    = 1'b0;
    cur_mode = m;
    sent     = 0;
    wr_cnt   = 0;
    in_run   = 1'b1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b, expected 1", busy);
    end
  endtask

  // Feed random windows until the frame is complete, then check the end.
  task automatic finish_frame(input int prob, input bit pulse_start);
    int n;
    bit pulsed;
    pulsed = 1'b0;
    while (sent < D) begin
      rand_win();
      if (pulse_start && !pulsed && sent == D / 2) begin
        start  = 1'b1;
        mode   = 2'(3 - cur_mode);
        pulsed = 1'b1;
      end
      send_window(($urandom_range(99) < prob) ? 1'b1 : 1'b0, 24'h0, 1'b0);
      start = 1'b0;
    end
    in_run = 1'b0;
    // Windows offered during DRAIN must be ignored.
    rand_win();
    send_window(1'b1, 24'h0, 1'b0);
    send_window(1'b1, 24'h0, 1'b0);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (done === 1'b1) break;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL done_timeout: oDone not seen within 200 cycles, required a pulse");
    end else begin
      checks++;
      if (cyc !== last_wr_cyc + 1) begin
        errors++;
        $display("FAIL done_timing: oDone at cycle %0d, expected %0d", cyc, last_wr_cyc + 1);
      end
    end
    checks++;
    if (wr_cnt !== D) begin
      errors++;
      $display("FAIL write_count: got %0d, expected %0d", wr_cnt, D);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL pending_expect: %0d left, expected 0", exp_q.size());
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done: done=%b busy=%b, expected 0 0", done, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (we !== 1'b0)     begin errors++; $display("FAIL reset_we: got %b, expected 0", we); end
    checks++; if (addr !== '0)     begin errors++; $display("FAIL reset_addr: got %0d, expected 0", addr); end
    checks++; if (pixel !== 24'h0) begin errors++; $display("FAIL reset_pixel: got %h, expected 000000", pixel); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_ignored();
    for (int i = 0; i < 6; i++) begin
      rand_win();
      send_window(1'b1, 24'h0, 1'b0);
    end
    @(negedge clk);
    checks++;
    if (we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: we=%b busy=%b, expected 0 0", we, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    start_frame(0, 1'b0);
    rand_win();
    valid = 1'b1;
    exp_q.push_back(win[4]);
    sent++;
    @(posedge clk);  // acceptance edge N
    #1 valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      checks++;
      if (we !== (j == 3)) begin
        errors++;
        $display("FAIL latency_edge_N+%0d: we=%b, expected %b", j, we, (j == 3));
      end
    end
    finish_frame(100, 1'b0);
  endtask

  task automatic test_bypass();
    logic [7:0] i;
    start_frame(0, 1'b1);
    while (sent < D) begin
      i = 8'(sent);
      rand_win();
      win[4] = {i, i, i};
      send_window(1'b1, {i, i, i}, 1'b1);
    end
    finish_frame(100, 1'b0);
  endtask

  task automatic test_gaussian();
    start_frame(1, 1'b0);
    set_win(24'h102030, 24'h102030, 24'h102030);
    send_window(1'b1, 24'h102030, 1'b1);
    set_win(24'hFF0000, 24'h000000, 24'h000000);
    send_window(1'b1, 24'h3F0000, 1'b1);  // 4*255 = 1020, >>4 = 63
    finish_frame(80, 1'b0);
  endtask

  task automatic test_sharpen();
    start_frame(2, 1'b0);
    set_win(24'h808080, 24'h000000, 24'h000000);
    send_window(1'b1, 24'hFFFFFF, 1'b1);
    set_win(24'h000000, 24'hFFFFFF, 24'h000000);
    send_window(1'b1, 24'h000000, 1'b1);
    finish_frame(70, 1'b0);
  endtask

  task automatic test_laplacian();
    start_frame(3, 1'b0);
    set_win(24'h555555, 24'h555555, 24'h555555);
    send_window(1'b1, 24'h000000, 1'b1);
    set_win(24'hFF00FF, 24'h000000, 24'h000000);
    send_window(1'b1, 24'hFF00FF, 1'b1);
    finish_frame(90, 1'b0);
  endtask

  task automatic test_random_frame();
    start_frame(int'($urandom_range(3)), 1'b0);
    finish_frame(50, 1'b1);
  endtask

  task automatic test_midframe_reset();
    start_frame(1, 1'b0);
    for (int i = 0; i < 60; i++) begin
      rand_win();
      send_window(1'b1, 24'h0, 1'b0);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (we !== 1'b0)     begin errors++; $display("FAIL midreset_we: got %b, expected 0", we); end
    checks++; if (addr !== '0)     begin errors++; $display("FAIL midreset_addr: got %0d, expected 0", addr); end
    checks++; if (pixel !== 24'h0) begin errors++; $display("FAIL midreset_pixel: got %h, expected 000000", pixel); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL midreset_busy: got %b, expected 0", busy); end
    exp_q.delete();
    exp_addr = 0;
    in_run   = 1'b0;
    sent     = 0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    start_frame(2, 1'b0);
    finish_frame(100, 1'b0);
  endtask

  initial begin
    rand_win();
    test_reset();
    test_idle_ignored();
    test_latency();
    test_bypass();
    test_gaussian();
    test_sharpen();
    test_laplacian();
    test_random_frame();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
